// File: rtl/iir_sos_ctrl_pkg.sv
// Shared encodings for the IIR cascade controller: FSM states, coefficient addresses, window length.
// Pure constants and one helper; no logic, no latency, no backpressure.
package iir_ctrl_pkg;

   localparam int SEC_CYC = 4;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CFG  = 3'd1;
   localparam logic [2:0] ST_PRE  = 3'd2;
   localparam logic [2:0] ST_C1   = 3'd3;
   localparam logic [2:0] ST_C2   = 3'd4;
   // The section window PRE..FIN occupies SEC_CYC consecutive encodings.
   localparam logic [2:0] ST_FIN  = ST_PRE + 3'(SEC_CYC - 1);

   localparam logic [1:0] C_ADDR_A0 = 2'd0;
   localparam logic [1:0] C_ADDR_A1 = 2'd1;
   localparam logic [1:0] C_ADDR_B  = 2'd2;
   localparam logic [1:0] C_ADDR_K  = 2'd3;

   function automatic logic [1:0] addr_next(input logic [1:0] a);
      logic [1:0] n;
      n = C_ADDR_A0;
      case (a)
         C_ADDR_A0: n = C_ADDR_A1;
         C_ADDR_A1: n = C_ADDR_B;
         C_ADDR_B:  n = C_ADDR_K;
         default:   n = C_ADDR_A0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/iir_sos_ctrl_if.sv
// Host-facing bundle of the cascade controller: sample/config handshakes and section strobes.
// master = host/cascade side, slave = controller side.
interface iir_sos_ctrl_if #(
   parameter int NUM_SEC = 4,
   parameter int CW      = 16
);
   logic               samp_valid;
   logic               samp_ready;
   logic               out_valid;
   logic [NUM_SEC-1:0] ce;
   logic               mult_sel;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [CW-1:0]      cfg_data;
   logic               cfg_restart;
   logic [NUM_SEC-1:0] c_we;
   logic [1:0]         c_addr;
   logic [CW-1:0]      c_in;
   logic               ovr;
   logic               ovr_clr;

   modport master (
      output samp_valid, cfg_valid, cfg_data, cfg_restart, ovr_clr,
      input  samp_ready, out_valid, ce, mult_sel, cfg_ready, c_we, c_addr, c_in, ovr
   );

   modport slave (
      input  samp_valid, cfg_valid, cfg_data, cfg_restart, ovr_clr,
      output samp_ready, out_valid, ce, mult_sel, cfg_ready, c_we, c_addr, c_in, ovr
   );
endinterface

// File: rtl/iir_sos_ctrl_coef_wptr.sv
// Coefficient write pointer: (section, address) walking a0,a1,b,K per section with wrap; restart wins.
// Registered pointer, one-hot section decode is combinational; no backpressure.
module iir_coef_wptr
   import iir_ctrl_pkg::*;
#(
   parameter int NUM_SEC = 4,
   parameter int SEC_W   = 2
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               inc,
   input  logic               restart,
   output logic [NUM_SEC-1:0] sec_hot,
   output logic [1:0]         addr
);
   logic [SEC_W-1:0] wsec;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wsec <= '0;
         addr <= C_ADDR_A0;
      end else if (restart) begin
         wsec <= '0;
         addr <= C_ADDR_A0;
      end else if (inc) begin
         addr <= addr_next(addr);
         if (addr == C_ADDR_K)
            wsec <= (wsec == SEC_W'(NUM_SEC - 1)) ? '0 : wsec + 1'b1;
      end
   end

   assign sec_hot = NUM_SEC'(1) << wsec;

endmodule

// File: rtl/iir_sos_ctrl.sv
// Cascade sequencer: 4-cycle ce/mult_sel window per section, out_valid T+4*NUM_SEC+1 after sample accept.
// Samples arriving while busy are dropped and flag ovr; config words wait in IDLE (sample wins ties).
module iir_sos_ctrl
   import iir_ctrl_pkg::*;
#(
   parameter int NUM_SEC  = 4,
   parameter int SEC_W    = 2,
   parameter int COEFF_WH = 2,
   parameter int COEFF_FR = 14
) (
   input  logic           clk,
   input  logic           nrst,
   iir_sos_ctrl_if.slave  bus
);
   localparam int CW = COEFF_WH + COEFF_FR;

   logic [2:0]         state;
   logic [SEC_W-1:0]   sec;
   logic [NUM_SEC-1:0] ce_q;
   logic               ms_q;
   logic               ov_q;
   logic               ovr_q;
   logic [CW-1:0]      c_in_q;
   logic               idle;
   logic               in_cfg;
   logic               last_sec;
   logic [NUM_SEC-1:0] sec_hot;
   logic [NUM_SEC-1:0] wsec_hot;
   logic [1:0]         waddr;

   assign idle     = (state == ST_IDLE);
   assign in_cfg   = (state == ST_CFG);
   assign last_sec = (sec == SEC_W'(NUM_SEC - 1));
   assign sec_hot  = NUM_SEC'(1) << sec;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state  <= ST_IDLE;
         sec    <= '0;
         ce_q   <= '0;
         ms_q   <= 1'b0;
         ov_q   <= 1'b0;
         c_in_q <= '0;
      end else begin
         ov_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.samp_valid) begin
                  state <= ST_PRE;
                  sec   <= '0;
               end else if (bus.cfg_valid) begin
                  state  <= ST_CFG;
                  c_in_q <= bus.cfg_data;
               end
            end
            ST_CFG: state <= ST_IDLE;
            ST_PRE: begin
               state <= ST_C1;
               ce_q  <= sec_hot;
               ms_q  <= 1'b1;
            end
            ST_C1: state <= ST_C2;
            ST_C2: begin
               state <= ST_FIN;
               ce_q  <= '0;
               ms_q  <= 1'b0;
            end
            ST_FIN: begin
               if (last_sec) begin
                  state <= ST_IDLE;
                  ov_q  <= 1'b1;
               end else begin
                  state <= ST_PRE;
                  sec   <= sec + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               ce_q  <= '0;
               ms_q  <= 1'b0;
            end
         endcase
      end
   end

   // A dropped sample outranks a same-cycle clear so no overrun goes unseen.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         ovr_q <= 1'b0;
      else if (bus.samp_valid && !idle)
         ovr_q <= 1'b1;
      else if (bus.ovr_clr)
         ovr_q <= 1'b0;
   end

   iir_coef_wptr #(
      .NUM_SEC (NUM_SEC),
      .SEC_W   (SEC_W)
   ) u_wptr (
      .clk     (clk),
      .nrst    (nrst),
      .inc     (in_cfg),
      .restart (bus.cfg_restart),
      .sec_hot (wsec_hot),
      .addr    (waddr)
   );

   assign bus.samp_ready = idle;
   assign bus.cfg_ready  = idle & ~bus.samp_valid;
   assign bus.out_valid  = ov_q;
   assign bus.ce         = ce_q;
   assign bus.mult_sel   = ms_q;
   assign bus.c_we       = in_cfg ? wsec_hot : '0;
   assign bus.c_addr     = in_cfg ? waddr : C_ADDR_A0;
   assign bus.c_in       = c_in_q;
   assign bus.ovr        = ovr_q;

endmodule

// File: tb/tb_iir_sos_ctrl.sv
// Directed bench for iir_sos_ctrl with NUM_SEC=2: config walk, sample timing, overrun, arbitration, restart, reset.
module tb_iir_sos_ctrl;
   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   iir_sos_ctrl_if #(.NUM_SEC(2), .CW(16)) bus ();

   iir_sos_ctrl #(
      .NUM_SEC  (2),
      .SEC_W    (1),
      .COEFF_WH (2),
      .COEFF_FR (14)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Entered and left at posedge+1 with the controller in IDLE.
   task automatic cfg_word(input logic [15:0] d, input int we, input int a);
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = d;
      mid();
      chk("cfg_ready_accept", 32'(bus.cfg_ready), 1);
      nxt();
      bus.cfg_valid = 1'b0;
      mid();
      chk("c_we", 32'(bus.c_we), we);
      chk("c_addr", 32'(bus.c_addr), a);
      chk("c_in", 32'(bus.c_in), 32'(d));
      nxt();
   endtask

   initial begin
      int exp_ce;
      bus.samp_valid  = 1'b0;
      bus.cfg_valid   = 1'b0;
      bus.cfg_data    = '0;
      bus.cfg_restart = 1'b0;
      bus.ovr_clr     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      mid();
      chk("rst_samp_ready", 32'(bus.samp_ready), 1);
      chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_ce", 32'(bus.ce), 0);
      chk("rst_mult_sel", 32'(bus.mult_sel), 0);
      chk("rst_c_we", 32'(bus.c_we), 0);
      chk("rst_c_addr", 32'(bus.c_addr), 0);
      chk("rst_c_in", 32'(bus.c_in), 0);
      chk("rst_ovr", 32'(bus.ovr), 0);
      #1 nrst = 1'b1;
      nxt();

      // Eight coefficient words fill both sections
      for (int i = 1; i <= 8; i++)
         cfg_word(16'(i), (i <= 4) ? 1 : 2, (i - 1) % 4);

      // Single sample: window timing relative to the accept cycle
      bus.samp_valid = 1'b1;
      mid();
      chk("samp_ready_accept", 32'(bus.samp_ready), 1);
      nxt();
      bus.samp_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         mid();
         exp_ce = (k == 2 || k == 3) ? 1 : (k == 6 || k == 7) ? 2 : 0;
         chk("seq_ce", 32'(bus.ce), exp_ce);
         chk("seq_mult_sel", 32'(bus.mult_sel), (exp_ce != 0) ? 1 : 0);
         chk("seq_out_valid", 32'(bus.out_valid), (k == 9) ? 1 : 0);
         if (k == 9)
            chk("seq_ready_again", 32'(bus.samp_ready), 1);
         nxt();
      end

      // samp_valid held high: accept every 9th cycle, overrun, set-wins, clear
      for (int j = 0; j <= 28; j++) begin
         case (j)
            0:  bus.samp_valid = 1'b1;
            19: bus.samp_valid = 1'b0;
            20: begin bus.samp_valid = 1'b1; bus.ovr_clr = 1'b1; end
            21: begin bus.samp_valid = 1'b0; bus.ovr_clr = 1'b0; end
            27: bus.ovr_clr = 1'b1;
            28: bus.ovr_clr = 1'b0;
            default: ;
         endcase
         mid();
         if (j <= 18)
            chk("held_samp_ready", 32'(bus.samp_ready), (j % 9 == 0) ? 1 : 0);
         chk("held_out_valid", 32'(bus.out_valid), (j == 9 || j == 18 || j == 27) ? 1 : 0);
         if (j <= 1)
            chk("ovr_before", 32'(bus.ovr), 0);
         else if (j == 21)
            chk("ovr_set_wins", 32'(bus.ovr), 1);
         else if (j == 28)
            chk("ovr_cleared", 32'(bus.ovr), 0);
         else
            chk("ovr_sticky", 32'(bus.ovr), 1);
         nxt();
      end

      // Sample and cfg together: sample wins, cfg taken once idle again
      for (int j = 0; j <= 10; j++) begin
         case (j)
            0: begin bus.samp_valid = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_data = 16'h00AA; end
            1: bus.samp_valid = 1'b0;
            10: bus.cfg_valid = 1'b0;
            default: ;
         endcase
         mid();
         if (j == 0)
            chk("tie_samp_ready", 32'(bus.samp_ready), 1);
         if (j <= 8)
            chk("tie_cfg_ready", 32'(bus.cfg_ready), 0);
         if (j == 2)
            chk("tie_ce", 32'(bus.ce), 1);
         if (j == 9) begin
            chk("tie_out_valid", 32'(bus.out_valid), 1);
            chk("tie_cfg_ready_idle", 32'(bus.cfg_ready), 1);
         end
         if (j == 10) begin
            chk("tie_c_we", 32'(bus.c_we), 1);
            chk("tie_c_addr", 32'(bus.c_addr), 0);
            chk("tie_c_in", 32'(bus.c_in), 32'h00AA);
            chk("tie_ovr", 32'(bus.ovr), 0);
         end
         nxt();
      end

      // Pointer now at section 0 addr 1; three words reach addr 3, restart rewinds
      cfg_word(16'h0011, 1, 1);
      cfg_word(16'h0012, 1, 2);
      cfg_word(16'h0013, 1, 3);
      bus.cfg_restart = 1'b1;
      nxt();
      bus.cfg_restart = 1'b0;
      cfg_word(16'h0014, 1, 0);

      // Reset during section 1 C2, with ovr set and pointer advanced
      for (int j = 0; j <= 6; j++) begin
         case (j)
            0: bus.samp_valid = 1'b1;
            1: bus.samp_valid = 1'b0;
            2: bus.samp_valid = 1'b1;
            3: bus.samp_valid = 1'b0;
            default: ;
         endcase
         mid();
         if (j == 4)
            chk("pre_rst_ovr", 32'(bus.ovr), 1);
         nxt();
      end
      mid();
      chk("pre_rst_ce", 32'(bus.ce), 2);
      chk("pre_rst_mult_sel", 32'(bus.mult_sel), 1);
      #1 nrst = 1'b0;
      #1;
      chk("arst_ce", 32'(bus.ce), 0);
      chk("arst_mult_sel", 32'(bus.mult_sel), 0);
      chk("arst_out_valid", 32'(bus.out_valid), 0);
      chk("arst_samp_ready", 32'(bus.samp_ready), 1);
      repeat (2) @(posedge clk);
      mid();
      #1 nrst = 1'b1;
      nxt();
      for (int j = 0; j < 3; j++) begin
         mid();
         chk("post_rst_out_valid", 32'(bus.out_valid), 0);
         chk("post_rst_samp_ready", 32'(bus.samp_ready), 1);
         chk("post_rst_ovr", 32'(bus.ovr), 0);
         nxt();
      end
      cfg_word(16'h1234, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iir_sos_ctrl.md
Name: iir_sos_ctrl

Overview:
- Sequencer and configuration controller for a cascade of NUM_SEC iir_sos sections. Section k's din is driven by section k-1's dout.
- Runs per-section ce windows and the shared mult_sel so each section evaluates once per input sample, in cascade order.
- Serialises the coefficient-load stream into per-section c_we/c_addr/c_in writes.
- Arbitrates between sample processing and configuration, and flags sample overruns.

Parameters:
- NUM_SEC, 4, number of cascaded sections (1..16).
- SEC_W, 2, width of the section index; must satisfy 2**SEC_W >= NUM_SEC.
- COEFF_WH, 2, coefficient integer bits.
- COEFF_FR, 14, coefficient fractional bits.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- samp_valid  in  1  new input sample is present on the first section's din
- samp_ready  out  1  controller is idle and accepts a sample this cycle
- out_valid  out  1  one-cycle pulse: last section's dout holds the new result
- ce  out  NUM_SEC  per-section ce
- mult_sel  out  1  shared a-coefficient/delay select to all sections
- cfg_valid  in  1  coefficient word present
- cfg_ready  out  1  coefficient word accepted this cycle
- cfg_data  in  COEFF_WH+COEFF_FR  coefficient word
- cfg_restart  in  1  reset the write pointer to section 0, address 0
- c_we  out  NUM_SEC  per-section coefficient write enable
- c_addr  out  2  coefficient address: 0=a0, 1=a1, 2=b, 3=K
- c_in  out  COEFF_WH+COEFF_FR  registered copy of the accepted cfg_data
- ovr  out  1  sticky overrun flag
- ovr_clr  in  1  clears ovr

Behaviour:
- Reset: state IDLE, sec=0, wptr=0. All outputs are 0 except samp_ready and cfg_ready, which are 1 combinationally from IDLE.
- The reset is asynchronous, so a reset mid-sample abandons the sample; out_valid is not pulsed.
- States: IDLE, CFG, PRE, C1, C2, FIN.
- IDLE arbitration:
  - samp_valid=1 goes to PRE with sec=0, and wins over cfg_valid in the same cycle.
  - Otherwise cfg_valid=1 goes to CFG.
  - samp_ready = cfg_ready = (state==IDLE). When samp_valid and cfg_valid are both high, cfg_ready=0.
- CFG (1 cycle):
  - c_we[wptr_sec]=1, c_addr=wptr_addr, c_in=data latched at acceptance.
  - wptr increments; addr wraps 3->0 with sec+1; sec wraps NUM_SEC-1 -> 0.
  - Returns to IDLE.
- cfg_restart: applied in any state; zeroes wptr next cycle. It takes priority over the increment in the same cycle.
- Per-section window, 4 cycles, for section sec:
  - PRE: ce=0, mult_sel=0. The section's a0 product enters its pipeline register.
  - C1: ce[sec]=1, mult_sel=1. acc takes the a0 term.
  - C2: ce[sec]=1, mult_sel=1. acc takes the a1 term.
  - FIN: ce=0, mult_sel=0. The section sees the ce falling edge and updates its delays and dout.
- After FIN:
  - If sec<NUM_SEC-1: sec+1 and go to PRE.
  - Else: IDLE, with out_valid=1 in the first IDLE cycle.
- Only one ce bit is ever high. ce and mult_sel are registered outputs.
- Latency: samp_valid accepted at cycle T gives out_valid at T+4*NUM_SEC+1. A sample can be accepted again in that same cycle.
- Overrun: samp_valid=1 while samp_ready=0 sets ovr. The sample is dropped, never queued. ovr_clr clears ovr; set wins if both occur in the same cycle.
- The cascade data path is outside this block; it only times ce and mult_sel.

Decomposition:
- Package iir_ctrl_pkg holds:
  - state encoding constants (3-bit, IDLE=0);
  - C_ADDR_A0/A1/B/K constants;
  - SEC_CYC=4.
- Sub-module iir_coef_wptr: section/address write pointer with wrap and restart. It outputs a one-hot section decode for c_we.

Test Plan:
- Reset, then 8 cfg words 0x0001..0x0008 with NUM_SEC=2 -> c_we={01,01,01,01,10,10,10,10}, c_addr=0,1,2,3,0,1,2,3, c_in matches; 2-cycle spacing per word.
- One samp_valid at cycle 10 -> ce[0] high at cycles 12-13, ce[1] high at cycles 16-17, mult_sel=1 exactly those cycles, out_valid at cycle 19.
- samp_valid held high continuously -> accepts every 9th cycle (NUM_SEC=2), ovr=1 after the first cycle; ovr_clr pulse with no samp_valid -> ovr=0.
- samp_valid and cfg_valid both high in IDLE -> sample sequence runs, cfg_ready=0; cfg word accepted in the first IDLE cycle after out_valid.
- 3 cfg words, cfg_restart, 1 cfg word -> 4th write goes to c_we[0], c_addr=0.
- nrst low during C2 of section 1 -> ce=0, mult_sel=0, out_valid=0 immediately; after release samp_ready=1, wptr=0, ovr=0.
